cursor_paint_ctrl: RTL and testbench
====================================

Name: cursor_paint_ctrl

Overview:
- Generates the cursor position consumed by the VGA image display stage from five raw push-buttons.
- Writes the selected RGB111 colour into the frame BRAM write port at the cursor location.
- Sits between board buttons and the dual-port frame BRAM / display stage.
- Frame layout: 640x480, one byte per pixel, format 00000RGB, address = y*640 + x.

Parameters:
H_RES, 640, horizontal pixel count; cursor_x range 0..H_RES-1
V_RES, 480, vertical pixel count; cursor_y range 0..V_RES-1
DEBOUNCE_CYCLES, 250000, consecutive stable synchronized samples required to accept a level change (10 ms at 25 MHz)
REPEAT_DELAY, 12500000, hold time before auto-repeat starts (0.5 s)
REPEAT_RATE, 1250000, auto-repeat step period (50 ms)

Ports:
clk_25mhz  input  1  pixel clock; all logic on rising edge
reset  input  1  synchronous, active-high
btn_up  input  1  raw asynchronous button, active-high
btn_down  input  1  raw asynchronous button, active-high
btn_left  input  1  raw asynchronous button, active-high
btn_right  input  1  raw asynchronous button, active-high
btn_paint  input  1  raw asynchronous button, active-high
color_sel  input  3  {R,G,B} colour to paint; sampled on the write cycle
write_lock  input  1  high while another agent (image loader) owns the BRAM write port
cursor_x  output  10  registered cursor column
cursor_y  output  10  registered cursor row
bram_we  output  1  one-cycle write strobe
bram_waddr  output  19  registered write address
bram_wdata  output  8  registered write data {5'b0,color_sel}

Behaviour:
- Reset values: cursor_x=H_RES/2 (320), cursor_y=V_RES/2 (240), bram_we=0, bram_waddr=0, bram_wdata=0. All synchronizers, debouncers, counters and the FSM are cleared; a button held through reset is seen as a new press after release of reset plus debounce time.
- Each button passes through a 2-flop synchronizer, then a debouncer. The debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current debounced level; any mismatch-free sample restarts the count.
- Move vector per cycle: dx = right - left, dy = down - up, from debounced levels. Opposite buttons pressed together give 0 on that axis.
- Repeat FSM, shared by all four direction buttons, with a 24-bit timer:
  - IDLE: any direction goes from none pressed to some pressed → apply one step this cycle; go to DELAY; clear timer.
  - DELAY: no direction pressed → IDLE. Timer reaches REPEAT_DELAY-1 → step; go to REPEAT; clear timer.
  - REPEAT: no direction pressed → IDLE. Timer reaches REPEAT_RATE-1 → step; clear timer.
  - Adding or removing a second direction while in DELAY or REPEAT does not restart the timer; the next step uses the current vector.
- Step: cursor_x += dx and cursor_y += dy, clamped to 0..H_RES-1 and 0..V_RES-1. No wrap-around; a step at an edge leaves that axis unchanged. The cursor register updates on the clock edge following the step decision (1-cycle latency).
- Paint: on the rising edge of debounced paint with write_lock=0:
  - Next cycle: bram_we=1 for exactly one cycle.
  - bram_waddr = (cursor_y<<9)+(cursor_y<<7)+cursor_x, using the coordinates before any move in the same cycle.
  - bram_wdata = {5'b0,color_sel}.
- Paint edge while write_lock=1 is dropped, not queued. Motion is unaffected by write_lock.
- bram_waddr and bram_wdata hold their last values while bram_we=0.

Optional Feature:
- Macro PAINT_DRAG_EN defined: while debounced paint is held and write_lock=0, every cursor step that changes the position also issues a one-cycle write at the new position, one cycle after the cursor register updates. The initial press still writes the starting pixel.
- Macro not defined: exactly one write per paint press.

Test Plan:
- Sim parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5.
- Reset, then idle 50 cycles → cursor=(320,240), bram_we never asserted.
- btn_right pulsed high 2 cycles (bounce) → no movement. Held 10 cycles then released → cursor_x=321 exactly once.
- btn_down held 60 cycles → cursor_y steps at the initial press, +20 cycles, then every 5 cycles; total 1+1+ floor over the remaining hold checked against a cycle-accurate model.
- Drive cursor to (0,0) with left/up held long → cursor stays (0,0), never wraps to 639/479. Left+right held together → cursor_x unchanged.
- Cursor (10,2), color_sel=3'b101, paint press → one bram_we pulse, bram_waddr=1290, bram_wdata=8'h05. Same press with write_lock=1 → no pulse.
- PAINT_DRAG_EN: paint held plus right held 30 cycles from (5,0) → writes at addresses 5, 6, 7, … matching each cursor step; without the macro → only address 5.

Source files
------------

// File: rtl/cursor_paint_ctrl.sv
// Button-driven cursor with auto-repeat and single-pixel painting into the frame BRAM.
// Optional macro PAINT_DRAG_EN: keep painting at each new cursor position while paint is held.
`timescale 1ns/1ps

module cursor_paint_ctrl #(
  parameter int H_RES           = 640,
  parameter int V_RES           = 480,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 1250000
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_paint,
  input  logic [2:0]  color_sel,
  input  logic        write_lock,
  output logic [9:0]  cursor_x,
  output logic [9:0]  cursor_y,
  output logic        bram_we,
  output logic [18:0] bram_waddr,
  output logic [7:0]  bram_wdata
);

  // state    | meaning
  // S_IDLE   | no direction held; first press steps immediately
  // S_DELAY  | held, waiting REPEAT_DELAY before auto-repeat
  // S_REPEAT | held, stepping every REPEAT_RATE cycles
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  localparam int             DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0]    DELAY_TC = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0]    RATE_TC  = 24'(REPEAT_RATE - 1);
  localparam logic [9:0]     X_MAX    = 10'(H_RES - 1);
  localparam logic [9:0]     Y_MAX    = 10'(V_RES - 1);
  localparam logic [9:0]     X_RST    = 10'(H_RES / 2);
  localparam logic [9:0]     Y_RST    = 10'(V_RES / 2);

  // bit order: 0 up, 1 down, 2 left, 3 right, 4 paint
  logic [4:0]      w_btn_raw;
  logic [4:0]      r_sync1;
  logic [4:0]      r_sync2;
  logic [4:0]      r_db;
  logic [DB_W-1:0] r_db_cnt [5];

  assign w_btn_raw = {btn_paint, btn_right, btn_left, btn_down, btn_up};

  // Down-counter per button reloads on any agreeing sample, so only an
  // unbroken run of DEBOUNCE_CYCLES disagreeing samples flips the level.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      for (int i = 0; i < 5; i++) r_db_cnt[i] <= DB_LOAD;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= DB_LOAD;
        end else if (r_db_cnt[i] == '0) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= DB_LOAD;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] - 1'b1;
        end
      end
    end
  end

  logic w_dir_any;
  logic w_x_inc, w_x_dec, w_y_inc, w_y_dec;

  assign w_dir_any = |r_db[3:0];
  assign w_x_inc   = r_db[3] & ~r_db[2];
  assign w_x_dec   = r_db[2] & ~r_db[3];
  assign w_y_inc   = r_db[1] & ~r_db[0];
  assign w_y_dec   = r_db[0] & ~r_db[1];

  state_t      r_state, w_state_nxt;
  logic [23:0] r_timer, w_timer_nxt;
  logic        w_step;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + 24'd1;
    w_step      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (w_dir_any) begin
          w_step      = 1'b1;
          w_state_nxt = S_DELAY;
        end
      end
      S_DELAY: begin
        if (!w_dir_any) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == DELAY_TC) begin
          w_step      = 1'b1;
          w_state_nxt = S_REPEAT;
          w_timer_nxt = '0;
        end
      end
      S_REPEAT: begin
        if (!w_dir_any) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == RATE_TC) begin
          w_step      = 1'b1;
          w_timer_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  logic [9:0] w_x_nxt, w_y_nxt;

  always_comb begin
    w_x_nxt = cursor_x;
    w_y_nxt = cursor_y;
    if (w_step) begin
      if (w_x_inc && cursor_x != X_MAX)    w_x_nxt = cursor_x + 10'd1;
      else if (w_x_dec && cursor_x != '0)  w_x_nxt = cursor_x - 10'd1;
      if (w_y_inc && cursor_y != Y_MAX)    w_y_nxt = cursor_y + 10'd1;
      else if (w_y_dec && cursor_y != '0)  w_y_nxt = cursor_y - 10'd1;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      cursor_x <= X_RST;
      cursor_y <= Y_RST;
    end else begin
      cursor_x <= w_x_nxt;
      cursor_y <= w_y_nxt;
    end
  end

  logic        r_paint_d;
  logic        w_paint_rise;
  logic        w_wr_req;
  logic [18:0] w_addr;

  assign w_paint_rise = r_db[4] & ~r_paint_d;
  assign w_addr = {cursor_y, 9'b0} + {2'b0, cursor_y, 7'b0} + {9'b0, cursor_x};

`ifdef PAINT_DRAG_EN
  logic r_drag_pend;

  // Pending drag write lands when the cursor register already holds the new
  // position, so the same address path serves both press and drag writes.
  always_ff @(posedge clk_25mhz) begin
    if (reset) r_drag_pend <= 1'b0;
    else       r_drag_pend <= w_step & r_db[4] & ~write_lock &
                              ((w_x_nxt != cursor_x) | (w_y_nxt != cursor_y));
  end

  assign w_wr_req = ~write_lock & (w_paint_rise | r_drag_pend);
`else
  assign w_wr_req = ~write_lock & w_paint_rise;
`endif

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_paint_d  <= 1'b0;
      bram_we    <= 1'b0;
      bram_waddr <= '0;
      bram_wdata <= '0;
    end else begin
      r_paint_d <= r_db[4];
      bram_we   <= w_wr_req;
      if (w_wr_req) begin
        bram_waddr <= w_addr;
        bram_wdata <= {5'b0, color_sel};
      end
    end
  end

endmodule

// File: tb/tb_cursor_paint_ctrl.sv
// Directed bench for cursor_paint_ctrl with short debounce/repeat timing.
`timescale 1ns/1ps

module tb_cursor_paint_ctrl;

  localparam logic [4:0] UP = 5'b00001;
  localparam logic [4:0] DN = 5'b00010;
  localparam logic [4:0] LF = 5'b00100;
  localparam logic [4:0] RT = 5'b01000;
  localparam logic [4:0] PT = 5'b10000;

  logic        clk_25mhz = 1'b0;
  logic        reset = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_paint = 1'b0;
  logic [2:0]  color_sel = 3'b000;
  logic        write_lock = 1'b0;
  logic [9:0]  cursor_x, cursor_y;
  logic        bram_we;
  logic [18:0] bram_waddr;
  logic [7:0]  bram_wdata;

  always #20 clk_25mhz = ~clk_25mhz;

  cursor_paint_ctrl #(
    .H_RES(640), .V_RES(480),
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) dut (
    .clk_25mhz(clk_25mhz), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_paint(btn_paint),
    .color_sel(color_sel), .write_lock(write_lock),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: write log, cursor_y step times, jump (wrap) detection.
  int         cyc = 0;
  int         wr_addr_q[$];
  int         wr_data_q[$];
  int         y_step_cyc[$];
  bit         rec_y = 1'b0;
  bit         jump_seen = 1'b0;
  logic [9:0] prev_x, prev_y;

  always @(negedge clk_25mhz) begin
    cyc++;
    if (!reset) begin
      if (bram_we) begin
        wr_addr_q.push_back(int'(bram_waddr));
        wr_data_q.push_back(int'(bram_wdata));
      end
      if (rec_y && cursor_y != prev_y) y_step_cyc.push_back(cyc);
      if ((int'(cursor_x) - int'(prev_x)) > 1 || (int'(prev_x) - int'(cursor_x)) > 1 ||
          (int'(cursor_y) - int'(prev_y)) > 1 || (int'(prev_y) - int'(cursor_y)) > 1)
        jump_seen = 1'b1;
    end
    prev_x = cursor_x;
    prev_y = cursor_y;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  task automatic press(input logic [4:0] m, input int hold, input int settle);
    {btn_paint, btn_right, btn_left, btn_down, btn_up} = m;
    cycles(hold);
    {btn_paint, btn_right, btn_left, btn_down, btn_up} = 5'b0;
    cycles(settle);
  endtask

  typedef struct {
    logic [4:0] btns;
    int         hold;
    int         exp_x;
    int         exp_y;
  } vec_t;

  vec_t vecs[10];
  int   exp_off[9];
  int   n_wr;

  initial begin
    vecs = '{
      '{RT,      10, 321, 240},
      '{LF,      10, 320, 240},
      '{DN,      10, 320, 241},
      '{UP,      10, 320, 240},
      '{LF | RT, 30, 320, 240},
      '{UP | DN, 30, 320, 240},
      '{RT | UP, 10, 321, 239},
      '{LF | DN, 10, 320, 240},
      '{RT,      25, 322, 240},
      '{LF,      25, 320, 240}
    };
    exp_off = '{0, 20, 25, 30, 35, 40, 45, 50, 55};

    reset = 1'b1;
    cycles(5);
    check("rst_x", cursor_x, 320);
    check("rst_y", cursor_y, 240);
    check("rst_we", bram_we, 0);
    check("rst_waddr", bram_waddr, 0);
    check("rst_wdata", bram_wdata, 0);
    reset = 1'b0;
    cycles(50);
    check("idle_x", cursor_x, 320);
    check("idle_y", cursor_y, 240);
    check("idle_writes", wr_addr_q.size(), 0);

    press(RT, 2, 20);
    check("bounce_x", cursor_x, 320);

    foreach (vecs[i]) begin
      press(vecs[i].btns, vecs[i].hold, 15);
      check($sformatf("vec%0d_x", i), cursor_x, vecs[i].exp_x);
      check($sformatf("vec%0d_y", i), cursor_y, vecs[i].exp_y);
    end

    rec_y = 1'b1;
    press(DN, 60, 15);
    rec_y = 1'b0;
    check("hold60_steps", y_step_cyc.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < y_step_cyc.size())
        check($sformatf("hold60_off%0d", i), y_step_cyc[i] - y_step_cyc[0], exp_off[i]);
    check("hold60_y", cursor_y, 249);

    press(LF | UP, 2000, 15);
    check("corner_x", cursor_x, 0);
    check("corner_y", cursor_y, 0);
    press(LF | UP, 40, 15);
    check("corner2_x", cursor_x, 0);
    check("corner2_y", cursor_y, 0);
    check("no_wrap", jump_seen, 0);

    for (int i = 0; i < 10; i++) press(RT, 10, 15);
    for (int i = 0; i < 2; i++)  press(DN, 10, 15);
    check("goto_x", cursor_x, 10);
    check("goto_y", cursor_y, 2);

    color_sel = 3'b101;
    press(PT, 10, 15);
    check("paint_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() >= 1) begin
      check("paint_addr", wr_addr_q[0], 1290);
      check("paint_data", wr_data_q[0], 5);
    end
    check("paint_we_low", bram_we, 0);
    check("paint_addr_hold", bram_waddr, 1290);
    check("paint_data_hold", bram_wdata, 5);

    write_lock = 1'b1;
    color_sel  = 3'b010;
    press(PT, 10, 15);
    check("lock_count", wr_addr_q.size(), 1);
    check("lock_addr_hold", bram_waddr, 1290);
    press(RT, 10, 15);
    check("lock_move_x", cursor_x, 11);
    write_lock = 1'b0;
    press(LF, 10, 15);
    check("unlock_move_x", cursor_x, 10);

    for (int i = 0; i < 5; i++) press(LF, 10, 15);
    for (int i = 0; i < 2; i++) press(UP, 10, 15);
    check("drag_start_x", cursor_x, 5);
    check("drag_start_y", cursor_y, 0);

    color_sel = 3'b011;
    n_wr = wr_addr_q.size();
    press(PT | RT, 30, 20);
    check("drag_end_x", cursor_x, 8);
`ifdef PAINT_DRAG_EN
    check("drag_count", wr_addr_q.size() - n_wr, 4);
    for (int i = 0; i < 4; i++)
      if (n_wr + i < wr_addr_q.size()) begin
        check($sformatf("drag_addr%0d", i), wr_addr_q[n_wr + i], 5 + i);
        check($sformatf("drag_data%0d", i), wr_data_q[n_wr + i], 3);
      end
`else
    check("drag_count", wr_addr_q.size() - n_wr, 1);
    if (n_wr < wr_addr_q.size()) begin
      check("drag_addr0", wr_addr_q[n_wr], 5);
      check("drag_data0", wr_data_q[n_wr], 3);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(40 * 50000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
